spi_slave_rx: RTL and testbench
===============================

SPI_SLAVE_RX -- requirements
Module: spi_slave_rx

Interface
REQ-001 SHALL have parameter WIDTH, default 8, frame length in bits (2..32).
REQ-002 SHALL have parameter MSB_FIRST, default 1: 1 = first received bit lands in bit WIDTH-1, 0 = first bit lands in bit 0.
REQ-003 SHALL have port i_clock  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port i_reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port i_sclk  input  1  serial clock from the SPI master; asynchronous to i_clock.
REQ-006 SHALL have port i_mosi  input  1  serial data from the master; valid on i_sclk rising edge.
REQ-007 SHALL have port i_ss_n  input  1  active-low slave select; asynchronous.
REQ-008 SHALL have port i_ack  input  1  consumer accepts o_data while o_valid is high.
REQ-009 SHALL have port o_data  output  WIDTH  last received frame.
REQ-010 SHALL have port o_valid  output  1  o_data holds an unconsumed frame.
REQ-011 SHALL have port o_busy  output  1  a frame is partially received.
REQ-012 SHALL have port o_overrun  output  1  sticky: a frame completed while o_valid was high.
REQ-013 SHALL have port o_frame_err  output  1  one-cycle pulse: select released mid-frame.

Function
REQ-014 SHALL pass i_sclk, i_mosi and i_ss_n each through a 2-flop synchronizer, plus a third i_sclk stage for edge detection.
REQ-015 SHALL detect an sclk rising edge when the synchronized sclk is 1 and its delayed copy is 0; no other sclk transition is acted on.
REQ-016 SHALL require i_sclk high and low phases of at least 2 i_clock periods each; slower sclk is the supported range.
REQ-017 SHALL implement states IDLE and SHIFT.
REQ-018 IDLE -> SHIFT when the synchronized ss_n is 0; bit counter cleared and shift register cleared on entry.
REQ-019 In SHIFT, on each detected edge the synchronized mosi bit SHALL be shifted in per MSB_FIRST and the bit counter SHALL increment.
REQ-020 On the edge that completes bit WIDTH, the frame SHALL be delivered, the counter SHALL return to 0, and the state SHALL stay in SHIFT for back-to-back frames.
REQ-021 Delivery when o_valid is 0 SHALL load o_data and set o_valid on the next i_clock edge.
REQ-022 Delivery when o_valid is 1 and i_ack is 0 in that cycle SHALL discard the new frame, keep o_data unchanged, and set o_overrun.
REQ-023 Delivery in the same cycle as i_ack with o_valid 1 SHALL load the new frame, keep o_valid 1, and not set o_overrun.
REQ-024 i_ack with o_valid 1 and no delivery SHALL clear o_valid and o_overrun on the next edge; i_ack with o_valid 0 SHALL be ignored.
REQ-025 o_busy SHALL be 1 in SHIFT while the bit counter is nonzero, else 0.
REQ-026 Synchronized ss_n rising while in SHIFT with counter nonzero SHALL pulse o_frame_err for one cycle, discard the partial frame, and return to IDLE.
REQ-027 Synchronized ss_n rising with counter 0 SHALL return to IDLE without o_frame_err.
REQ-028 An sclk edge detected in the same cycle ss_n is seen high SHALL be ignored.
REQ-029 Edges detected in IDLE SHALL be ignored.
REQ-030 Latency SHALL be 2 synchronizer cycles plus 1 detect cycle plus 1 output cycle, i.e. o_valid rises 4 i_clock edges after the final i_sclk rising edge at the input.

Reset
REQ-031 i_reset high SHALL immediately force state IDLE, counter 0, shift register 0, and all synchronizer flops to idle (sclk 0, ss_n 1, mosi 0).
REQ-032 During reset, outputs SHALL be o_data 0, o_valid 0, o_busy 0, o_overrun 0 and o_frame_err 0.
REQ-033 Reset asserted mid-frame SHALL discard the partial frame without pulsing o_frame_err; reception resumes only after the next falling edge of ss_n after reset release.

Verification
REQ-034 Scenario: WIDTH=8, MSB_FIRST=1, sclk = i_clock/8, ss_n low, send 0xA5 -> o_data 0xA5, o_valid 1 exactly 4 clocks after the 8th sclk rise, o_busy 0 afterwards.
REQ-035 Scenario: back-to-back 0x3C then 0xC3 under one ss_n, ack after each -> two deliveries in order, o_overrun 0.
REQ-036 Scenario: send 0x11 with no ack, then 0x22 -> o_data stays 0x11, o_overrun 1; ack -> o_valid 0, o_overrun 0.
REQ-037 Scenario: raise ss_n after 5 bits -> single o_frame_err pulse, o_valid unchanged, next full frame 0x7E received correctly.
REQ-038 Scenario: MSB_FIRST=0, send bits 1,0,0,0,0,0,0,0 -> o_data 0x01.
REQ-039 Scenario: assert i_reset after 3 bits, release, drop ss_n, send 0xF0 -> no o_frame_err, o_data 0xF0.

Source files
------------

// File: rtl/spi_slave_rx.sv
// SPI slave receiver: WIDTH-bit frames from a synchronized sclk/mosi/ss_n; o_valid rises 4 clocks after the last sclk rise.
// Backpressure via o_valid/i_ack; a frame finishing while unconsumed is dropped and flagged on o_overrun.
module spi_slave_rx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_sclk,
  input  logic             i_mosi,
  input  logic             i_ss_n,
  input  logic             i_ack,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_busy,
  output logic             o_overrun,
  output logic             o_frame_err
);

  localparam int CW = (WIDTH <= 2) ? 1 : $clog2(WIDTH);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic             sclk_s1, sclk_s2, sclk_s3;
  logic             mosi_s1, mosi_s2;
  logic             ss_s1, ss_s2;
  logic [0:0]       state;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shift_next;
  logic             frame_done;
  logic             sclk_rise;
  logic             last_bit;

  // Synchronizers idle at sclk 0, ss_n 1, mosi 0 so reset never looks like activity.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_s3 <= 1'b0;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
      ss_s1   <= 1'b1;
      ss_s2   <= 1'b1;
    end else begin
      sclk_s1 <= i_sclk;
      sclk_s2 <= sclk_s1;
      sclk_s3 <= sclk_s2;
      mosi_s1 <= i_mosi;
      mosi_s2 <= mosi_s1;
      ss_s1   <= i_ss_n;
      ss_s2   <= ss_s1;
    end
  end

  assign sclk_rise = sclk_s2 & ~sclk_s3;
  assign last_bit  = (bit_cnt == CW'(WIDTH - 1));

  generate
    if (MSB_FIRST) begin : g_msb
      assign shift_next = {shift_reg[WIDTH-2:0], mosi_s2};
    end else begin : g_lsb
      assign shift_next = {mosi_s2, shift_reg[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      frame_done  <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      frame_done  <= 1'b0;
      o_frame_err <= 1'b0;
      if (state == IDLE) begin
        if (!ss_s2) begin
          state     <= SHIFT;
          bit_cnt   <= '0;
          shift_reg <= '0;
        end
      end else begin
        // Deselect takes priority over a coincident sclk edge.
        if (ss_s2) begin
          state       <= IDLE;
          o_frame_err <= (bit_cnt != '0);
          bit_cnt     <= '0;
          shift_reg   <= '0;
        end else if (sclk_rise) begin
          shift_reg <= shift_next;
          if (last_bit) begin
            bit_cnt    <= '0;
            frame_done <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
      end
    end
  end

  // shift_reg still holds the completed frame here; the next bit is several clocks away.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      o_data    <= '0;
      o_valid   <= 1'b0;
      o_overrun <= 1'b0;
    end else if (frame_done) begin
      if (!o_valid) begin
        o_data  <= shift_reg;
        o_valid <= 1'b1;
      end else if (i_ack) begin
        o_data    <= shift_reg;
        o_overrun <= 1'b0;
      end else begin
        o_overrun <= 1'b1;
      end
    end else if (i_ack && o_valid) begin
      o_valid   <= 1'b0;
      o_overrun <= 1'b0;
    end
  end

  assign o_busy = (state == SHIFT) && (bit_cnt != '0);

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx: MSB-first and LSB-first instances share the serial inputs and ack.
`timescale 1ns/1ps
module tb_spi_slave_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sclk = 1'b0;
  logic       mosi = 1'b0;
  logic       ss_n = 1'b1;
  logic       ack = 1'b0;
  logic [7:0] m_data, l_data;
  logic       m_valid, m_busy, m_ovr, m_ferr;
  logic       l_valid, l_busy, l_ovr, l_ferr;

  int total = 0;
  int bad = 0;
  int ferr_cnt = 0;

  spi_slave_rx #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
    .i_clock(clk), .i_reset(rst), .i_sclk(sclk), .i_mosi(mosi), .i_ss_n(ss_n), .i_ack(ack),
    .o_data(m_data), .o_valid(m_valid), .o_busy(m_busy), .o_overrun(m_ovr), .o_frame_err(m_ferr)
  );

  spi_slave_rx #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .i_clock(clk), .i_reset(rst), .i_sclk(sclk), .i_mosi(mosi), .i_ss_n(ss_n), .i_ack(ack),
    .o_data(l_data), .o_valid(l_valid), .o_busy(l_busy), .o_overrun(l_ovr), .o_frame_err(l_ferr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (m_ferr) ferr_cnt++;

  // sclk = clk/8: 4 clocks low with mosi set up, then 4 clocks high.
  task automatic send_bit(input logic b);
    mosi = b;
    sclk = 1'b0;
    repeat (4) @(negedge clk);
    sclk = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic select_slave();
    sclk = 1'b0;
    ss_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic deselect_slave();
    sclk = 1'b0;
    ss_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic do_ack();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++; if (m_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", m_data); end
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", m_valid); end
    total++; if (m_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", m_busy); end
    total++; if (m_ovr !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b want=0", m_ovr); end
    total++; if (m_ferr !== 1'b0) begin bad++; $display("FAIL reset_frame_err got=%b want=0", m_ferr); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_latency();
    logic [7:0] v;
    int e0;
    v = 8'hA5;
    e0 = ferr_cnt;
    select_slave();
    for (int i = 7; i >= 1; i--) send_bit(v[i]);
    total++; if (m_busy !== 1'b1) begin bad++; $display("FAIL lat_busy_mid got=%b want=1", m_busy); end
    mosi = v[0];
    sclk = 1'b0;
    repeat (4) @(negedge clk);
    sclk = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL lat_valid_early got=%b want=0", m_valid); end
    @(negedge clk);
    total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL lat_valid_4clk got=%b want=1", m_valid); end
    total++; if (m_data !== 8'hA5) begin bad++; $display("FAIL lat_data got=%h want=a5", m_data); end
    total++; if (m_busy !== 1'b0) begin bad++; $display("FAIL lat_busy_after got=%b want=0", m_busy); end
    do_ack();
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL lat_ack_clears got=%b want=0", m_valid); end
    deselect_slave();
    total++; if (ferr_cnt - e0 !== 0) begin bad++; $display("FAIL lat_no_frame_err got=%0d want=0", ferr_cnt - e0); end
  endtask

  task automatic test_back_to_back();
    select_slave();
    send_byte(8'h3C);
    total++; if (m_data !== 8'h3C || m_valid !== 1'b1) begin bad++; $display("FAIL b2b_first got=%h/%b want=3c/1", m_data, m_valid); end
    do_ack();
    send_byte(8'hC3);
    total++; if (m_data !== 8'hC3 || m_valid !== 1'b1) begin bad++; $display("FAIL b2b_second got=%h/%b want=c3/1", m_data, m_valid); end
    total++; if (m_ovr !== 1'b0) begin bad++; $display("FAIL b2b_overrun got=%b want=0", m_ovr); end
    do_ack();
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL b2b_drained got=%b want=0", m_valid); end
    deselect_slave();
  endtask

  task automatic test_overrun();
    select_slave();
    send_byte(8'h11);
    total++; if (m_data !== 8'h11 || m_valid !== 1'b1) begin bad++; $display("FAIL ovr_first got=%h/%b want=11/1", m_data, m_valid); end
    send_byte(8'h22);
    total++; if (m_data !== 8'h11) begin bad++; $display("FAIL ovr_data_kept got=%h want=11", m_data); end
    total++; if (m_ovr !== 1'b1 || m_valid !== 1'b1) begin bad++; $display("FAIL ovr_flag got=%b/%b want=1/1", m_ovr, m_valid); end
    do_ack();
    total++; if (m_valid !== 1'b0 || m_ovr !== 1'b0) begin bad++; $display("FAIL ovr_ack_clear got=%b/%b want=0/0", m_valid, m_ovr); end
    deselect_slave();
  endtask

  task automatic test_frame_err();
    int e0;
    logic vb;
    e0 = ferr_cnt;
    vb = m_valid;
    select_slave();
    for (int i = 0; i < 5; i++) send_bit(i[0]);
    total++; if (m_busy !== 1'b1) begin bad++; $display("FAIL ferr_busy_mid got=%b want=1", m_busy); end
    deselect_slave();
    repeat (4) @(negedge clk);
    total++; if (ferr_cnt - e0 !== 1) begin bad++; $display("FAIL ferr_pulse_count got=%0d want=1", ferr_cnt - e0); end
    total++; if (m_valid !== vb) begin bad++; $display("FAIL ferr_valid_kept got=%b want=%b", m_valid, vb); end
    total++; if (m_busy !== 1'b0) begin bad++; $display("FAIL ferr_busy_after got=%b want=0", m_busy); end
    select_slave();
    send_byte(8'h7E);
    total++; if (m_data !== 8'h7E || m_valid !== 1'b1) begin bad++; $display("FAIL ferr_next_frame got=%h/%b want=7e/1", m_data, m_valid); end
    do_ack();
    deselect_slave();
  endtask

  task automatic test_lsb_first();
    select_slave();
    send_byte(8'h80);
    total++; if (l_data !== 8'h01 || l_valid !== 1'b1) begin bad++; $display("FAIL lsb_data got=%h/%b want=01/1", l_data, l_valid); end
    total++; if (m_data !== 8'h80) begin bad++; $display("FAIL msb_same_bits got=%h want=80", m_data); end
    deselect_slave();
  endtask

  task automatic test_reset_mid_frame();
    int e0;
    select_slave();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    e0 = ferr_cnt;
    rst = 1'b1;
    #1;
    total++; if (m_valid !== 1'b0 || m_data !== 8'h00) begin bad++; $display("FAIL rst_mid_outputs got=%h/%b want=00/0", m_data, m_valid); end
    total++; if (m_busy !== 1'b0 || m_ovr !== 1'b0) begin bad++; $display("FAIL rst_mid_flags got=%b/%b want=0/0", m_busy, m_ovr); end
    ss_n = 1'b1;
    sclk = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    total++; if (m_valid !== 1'b0 || m_busy !== 1'b0) begin bad++; $display("FAIL rst_mid_idle got=%b/%b want=0/0", m_valid, m_busy); end
    select_slave();
    send_byte(8'hF0);
    total++; if (m_data !== 8'hF0 || m_valid !== 1'b1) begin bad++; $display("FAIL rst_mid_frame got=%h/%b want=f0/1", m_data, m_valid); end
    total++; if (ferr_cnt - e0 !== 0) begin bad++; $display("FAIL rst_mid_no_ferr got=%0d want=0", ferr_cnt - e0); end
    do_ack();
    deselect_slave();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_back_to_back();
    test_overrun();
    test_frame_err();
    test_lsb_first();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
